// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and helper functions for the pong game engine:
//               state encoding, direction encoding, serve/centre offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Direction bit: 1 means the coordinate is decreasing.
  localparam logic c_DIR_POS = 1'b0;
  localparam logic c_DIR_NEG = 1'b1;

  // Horizontal offset that centres the ball on top of the paddle.
  function automatic int serve_offset(input int pad_w, input int ball_w);
    return (pad_w - ball_w) / 2;
  endfunction

  // Left edge that centres an object of width obj_w on a screen of width scr_w.
  function automatic int centre_pos(input int scr_w, input int obj_w);
    return (scr_w - obj_w) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_engine_if
// Description : Bundle between the VGA timing / button front end (master)
//               and the pong game engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_engine_if #(
  parameter int CW      = 16,
  parameter int SCORE_W = 8
);
  logic               i_frame_tick;
  logic               i_btn_left;
  logic               i_btn_right;
  logic               i_btn_start;
  logic [CW-1:0]      i_x;
  logic [CW-1:0]      i_y;
  logic [CW-1:0]      o_ball_x;
  logic [CW-1:0]      o_ball_y;
  logic [CW-1:0]      o_pad_x;
  logic [2:0]         o_state;
  logic [2:0]         o_lives;
  logic [SCORE_W-1:0] o_score;
  logic               o_ball_on;
  logic               o_pad_on;
  logic [CW-1:0]      o_px;
  logic [CW-1:0]      o_py;
  logic [CW-1:0]      o_bx;
  logic [CW-1:0]      o_by;
  logic               o_bounce;
  logic               o_miss;

  modport master (
    output i_frame_tick, i_btn_left, i_btn_right, i_btn_start, i_x, i_y,
    input  o_ball_x, o_ball_y, o_pad_x, o_state, o_lives, o_score,
    input  o_ball_on, o_pad_on, o_px, o_py, o_bx, o_by, o_bounce, o_miss
  );

  modport slave (
    input  i_frame_tick, i_btn_left, i_btn_right, i_btn_start, i_x, i_y,
    output o_ball_x, o_ball_y, o_pad_x, o_state, o_lives, o_score,
    output o_ball_on, o_pad_on, o_px, o_py, o_bx, o_by, o_bounce, o_miss
  );
endinterface
`default_nettype wire

// File: rtl/pong_axis.sv
`default_nettype none
// ============================================================================
// Module      : pong_axis
// Description : One axis of ball motion. Steps the position by STEP in the
//               current direction, clamps at LO/HI and reflects the direction.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_axis
  import pong_pkg::*;
#(
  parameter int CW   = 16,
  parameter int LO   = 0,
  parameter int HI   = 624,
  parameter int STEP = 2
) (
  input  wire logic [CW-1:0] i_pos,
  input  wire logic          i_dir,
  input  wire logic          i_en,
  output logic      [CW-1:0] o_nxt_pos,
  output logic               o_nxt_dir,
  output logic               o_hit_lo,
  output logic               o_hit_hi
);
  localparam logic [CW:0] c_STEP = (CW+1)'(STEP);
  localparam logic [CW:0] c_LO   = (CW+1)'(LO);
  localparam logic [CW:0] c_HI   = (CW+1)'(HI);

  // One spare bit: an underflow below zero shows up as the top bit set.
  logic [CW:0] w_inc;
  logic [CW:0] w_dec;

  assign w_inc = {1'b0, i_pos} + c_STEP;
  assign w_dec = {1'b0, i_pos} - c_STEP;

  // Step, then clamp and reflect when the step reaches or crosses a limit.
  always_comb begin
    o_nxt_pos = i_pos;
    o_nxt_dir = i_dir;
    o_hit_lo  = 1'b0;
    o_hit_hi  = 1'b0;
    if (i_en) begin
      if (i_dir == c_DIR_NEG) begin
        if (w_dec[CW] || (w_dec <= c_LO)) begin
          o_nxt_pos = c_LO[CW-1:0];
          o_nxt_dir = c_DIR_POS;
          o_hit_lo  = 1'b1;
        end else begin
          o_nxt_pos = w_dec[CW-1:0];
        end
      end else begin
        if (w_inc >= c_HI) begin
          o_nxt_pos = c_HI[CW-1:0];
          o_nxt_dir = c_DIR_NEG;
          o_hit_hi  = 1'b1;
        end else begin
          o_nxt_pos = w_inc[CW-1:0];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/pong_engine.sv
`default_nettype none
// ============================================================================
// Module      : pong_engine
// Description : Frame-rate pong engine: paddle, ball, collisions, lives,
//               score, serve/play/miss/over FSM and per-pixel sprite hits.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_engine
  import pong_pkg::*;
#(
  parameter int CW          = 16,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_W      = 16,
  parameter int BALL_H      = 16,
  parameter int PAD_Y       = 440,
  parameter int PAD_W       = 96,
  parameter int PAD_H       = 12,
  parameter int BALL_DX     = 2,
  parameter int BALL_DY     = 2,
  parameter int PAD_SPEED   = 4,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60,
  parameter int SCORE_W     = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  pong_engine_if.slave bus
);
  localparam int c_CNT_W = $clog2(MISS_FRAMES + 1);

  localparam logic [CW:0] c_BW      = (CW+1)'(BALL_W);
  localparam logic [CW:0] c_BH      = (CW+1)'(BALL_H);
  localparam logic [CW:0] c_PW      = (CW+1)'(PAD_W);
  localparam logic [CW:0] c_PY      = (CW+1)'(PAD_Y);
  localparam logic [CW:0] c_DY      = (CW+1)'(BALL_DY);
  localparam logic [CW:0] c_SPD     = (CW+1)'(PAD_SPEED);
  localparam logic [CW:0] c_PAD_MAX = (CW+1)'(SCREEN_W - PAD_W);
  localparam logic [CW:0] c_PAD_END = (CW+1)'(PAD_Y + PAD_H);

  localparam logic [CW-1:0] c_PAD_BOT   = CW'(PAD_Y + PAD_H - 1);
  localparam logic [CW-1:0] c_PAD_CTR   = CW'(centre_pos(SCREEN_W, PAD_W));
  localparam logic [CW-1:0] c_SERVE_OFF = CW'(serve_offset(PAD_W, BALL_W));
  localparam logic [CW-1:0] c_SERVE_Y   = CW'(PAD_Y - BALL_H);
  localparam logic [CW-1:0] c_BALL_X0   = CW'(centre_pos(SCREEN_W, PAD_W) + serve_offset(PAD_W, BALL_W));

  localparam logic [2:0]         c_LIVES = 3'(LIVES);
  localparam logic [c_CNT_W-1:0] c_MISS  = c_CNT_W'(MISS_FRAMES);

  state_t             r_state;
  logic [CW-1:0]      r_ball_x, r_ball_y, r_pad_x;
  logic               r_dir_x, r_dir_y;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_bounce, r_miss;
  logic               r_ball_on, r_pad_on;
  logic [CW-1:0]      r_px, r_py, r_bx, r_by;

  logic [CW-1:0] w_x_nxt, w_y_nxt, w_pad_nxt;
  logic          w_x_dir, w_y_dir;
  logic          w_x_hit_lo, w_x_hit_hi, w_y_hit_lo, w_y_hit_hi;
  logic          w_play, w_pad_hit, w_in_ball, w_in_pad;
  logic [CW:0]   w_pad_l, w_pad_r, w_y_bot, w_y_bot_nxt, w_x, w_y;

  assign w_play = (r_state == ST_PLAY);

  pong_axis #(.CW(CW), .LO(0), .HI(SCREEN_W - BALL_W), .STEP(BALL_DX)) u_axis_x (
    .i_pos(r_ball_x), .i_dir(r_dir_x), .i_en(w_play),
    .o_nxt_pos(w_x_nxt), .o_nxt_dir(w_x_dir), .o_hit_lo(w_x_hit_lo), .o_hit_hi(w_x_hit_hi)
  );

  pong_axis #(.CW(CW), .LO(0), .HI(SCREEN_H - BALL_H), .STEP(BALL_DY)) u_axis_y (
    .i_pos(r_ball_y), .i_dir(r_dir_y), .i_en(w_play),
    .o_nxt_pos(w_y_nxt), .o_nxt_dir(w_y_dir), .o_hit_lo(w_y_hit_lo), .o_hit_hi(w_y_hit_hi)
  );

  assign w_pad_l = {1'b0, r_pad_x} - c_SPD;
  assign w_pad_r = {1'b0, r_pad_x} + c_SPD;

  // Paddle target for this tick; opposing buttons cancel out.
  always_comb begin
    w_pad_nxt = r_pad_x;
    if (bus.i_btn_left && !bus.i_btn_right) begin
      w_pad_nxt = w_pad_l[CW] ? '0 : w_pad_l[CW-1:0];
    end else if (bus.i_btn_right && !bus.i_btn_left) begin
      w_pad_nxt = (w_pad_r >= c_PAD_MAX) ? c_PAD_MAX[CW-1:0] : w_pad_r[CW-1:0];
    end
  end

  // Paddle catch uses the unclamped next position and the pre-tick paddle.
  assign w_y_bot     = {1'b0, r_ball_y} + c_BH;
  assign w_y_bot_nxt = w_y_bot + c_DY;
  assign w_pad_hit   = (r_dir_y == c_DIR_POS) && (w_y_bot_nxt >= c_PY) && (w_y_bot <= c_PY) &&
                       (({1'b0, r_ball_x} + c_BW) > {1'b0, r_pad_x}) &&
                       ({1'b0, r_ball_x} < ({1'b0, r_pad_x} + c_PW));

  // Game FSM: every piece of game state moves only on frame_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pad_x  <= c_PAD_CTR;
      r_ball_x <= c_BALL_X0;
      r_ball_y <= c_SERVE_Y;
      r_dir_x  <= c_DIR_POS;
      r_dir_y  <= c_DIR_POS;
      r_lives  <= c_LIVES;
      r_score  <= '0;
      r_cnt    <= '0;
      r_bounce <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      r_miss   <= 1'b0;
      if (bus.i_frame_tick) begin
        if (r_state != ST_OVER) r_pad_x <= w_pad_nxt;
        case (r_state)
          ST_IDLE: begin
            if (bus.i_btn_start) r_state <= ST_SERVE;
          end
          ST_SERVE: begin
            r_ball_x <= w_pad_nxt + c_SERVE_OFF;
            r_ball_y <= c_SERVE_Y;
            if (bus.i_btn_start) begin
              r_state <= ST_PLAY;
              r_dir_y <= c_DIR_NEG;
              r_dir_x <= bus.i_btn_left ? c_DIR_NEG : c_DIR_POS;
            end
          end
          ST_PLAY: begin
            r_ball_x <= w_x_nxt;
            r_dir_x  <= w_x_dir;
            r_bounce <= w_x_hit_lo | w_x_hit_hi | w_y_hit_lo | w_pad_hit;
            if (w_pad_hit) begin
              r_ball_y <= c_SERVE_Y;
              r_dir_y  <= c_DIR_NEG;
              if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
            end else if (w_y_hit_hi) begin
              r_ball_y <= w_y_nxt;
              r_miss   <= 1'b1;
              r_lives  <= r_lives - 1'b1;
              r_cnt    <= c_MISS;
              r_state  <= ST_MISS;
            end else begin
              r_ball_y <= w_y_nxt;
              r_dir_y  <= w_y_dir;
            end
          end
          ST_MISS: begin
            if ((r_cnt == '0) || (r_cnt == c_CNT_W'(1))) begin
              r_cnt   <= '0;
              r_state <= (r_lives == '0) ? ST_OVER : ST_SERVE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_OVER: begin
            if (bus.i_btn_start) begin
              r_lives <= c_LIVES;
              r_score <= '0;
              r_pad_x <= c_PAD_CTR;
              r_state <= ST_SERVE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_x = {1'b0, bus.i_x};
  assign w_y = {1'b0, bus.i_y};
  assign w_in_ball = (w_x >= {1'b0, r_ball_x}) && (w_x < ({1'b0, r_ball_x} + c_BW)) &&
                     (w_y >= {1'b0, r_ball_y}) && (w_y < ({1'b0, r_ball_y} + c_BH));
  assign w_in_pad  = (w_x >= {1'b0, r_pad_x}) && (w_x < ({1'b0, r_pad_x} + c_PW)) &&
                     (w_y >= c_PY) && (w_y < c_PAD_END);

  // Pixel pipeline: sprite hit and sprite-relative offsets, one cycle behind x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ball_on <= 1'b0;
      r_pad_on  <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_bx      <= '0;
      r_by      <= '0;
    end else begin
      r_ball_on <= w_in_ball;
      r_pad_on  <= w_in_pad;
      r_px      <= w_in_ball ? (bus.i_x - r_ball_x) : '0;
      r_py      <= w_in_ball ? (bus.i_y - r_ball_y) : '0;
      r_bx      <= w_in_pad ? (bus.i_x - r_pad_x) : '0;
      r_by      <= w_in_pad ? (c_PAD_BOT - bus.i_y) : '0;
    end
  end

  assign bus.o_ball_x  = r_ball_x;
  assign bus.o_ball_y  = r_ball_y;
  assign bus.o_pad_x   = r_pad_x;
  assign bus.o_state   = r_state;
  assign bus.o_lives   = r_lives;
  assign bus.o_score   = r_score;
  assign bus.o_bounce  = r_bounce;
  assign bus.o_miss    = r_miss;
  assign bus.o_ball_on = r_ball_on;
  assign bus.o_pad_on  = r_pad_on;
  assign bus.o_px      = r_px;
  assign bus.o_py      = r_py;
  assign bus.o_bx      = r_bx;
  assign bus.o_by      = r_by;
endmodule
`default_nettype wire

// File: tb/tb_pong_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_engine
// Description : Scoreboard bench for pong_engine. A driver issues randomized
//               ticks, buttons and pixel coordinates, a behavioural game model
//               pushes the expected outputs, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_engine;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4;

  typedef struct {
    int bx, by, pad, st, lives, score, bounce, miss;
    int ball_on, pad_on, px, py, qx, qy;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  // Behavioural game model (signed velocities, plain integers).
  int m_bx, m_by, m_pad, m_vx, m_vy, m_lives, m_score, m_st, m_pause;
  int m_bounce, m_miss, m_phit;

  pong_engine_if #(.CW(16), .SCORE_W(SW)) bus ();

  pong_engine #(.CW(16), .SCORE_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pad = 272; m_bx = 312; m_by = 424; m_vx = 1; m_vy = 1;
    m_lives = 3; m_score = 0; m_st = S_IDLE; m_pause = 0;
    m_bounce = 0; m_miss = 0; m_phit = 0;
  endfunction

  function automatic void model_tick(input bit l, input bit r, input bit s);
    int np, nx, ny;
    bit hit;
    m_bounce = 0; m_miss = 0; m_phit = 0;
    np = m_pad;
    if (l && !r) np = (m_pad - 4 < 0) ? 0 : m_pad - 4;
    else if (r && !l) np = (m_pad + 4 > 544) ? 544 : m_pad + 4;
    case (m_st)
      S_IDLE: begin
        m_pad = np;
        if (s) m_st = S_SERVE;
      end
      S_SERVE: begin
        m_pad = np; m_bx = np + 40; m_by = 424;
        if (s) begin m_st = S_PLAY; m_vy = -1; m_vx = l ? -1 : 1; end
      end
      S_PLAY: begin
        nx = m_bx + 2 * m_vx;
        ny = m_by + 2 * m_vy;
        if (nx <= 0) begin nx = 0; m_vx = 1; m_bounce = 1; end
        else if (nx >= 624) begin nx = 624; m_vx = -1; m_bounce = 1; end
        hit = (m_vy > 0) && (ny + 16 >= 440) && (m_by + 16 <= 440) &&
              (m_bx + 16 > m_pad) && (m_bx < m_pad + 96);
        m_bx = nx;
        m_pad = np;
        if (hit) begin
          m_by = 424; m_vy = -1; m_bounce = 1; m_phit = 1;
          if (m_score < SMAX) m_score++;
        end else if (ny >= 464) begin
          m_by = 464; m_miss = 1; m_lives--; m_pause = 60; m_st = S_MISS;
        end else if (ny <= 0) begin
          m_by = 0; m_vy = 1; m_bounce = 1;
        end else begin
          m_by = ny;
        end
      end
      S_MISS: begin
        m_pad = np;
        m_pause--;
        if (m_pause == 0) m_st = (m_lives == 0) ? S_OVER : S_SERVE;
      end
      default: begin
        if (s) begin m_lives = 3; m_score = 0; m_pad = 272; m_st = S_SERVE; end
      end
    endcase
  endfunction

  // One clock of stimulus; expectation reflects the state after the coming edge.
  task automatic step(input bit tk, input bit l, input bit r, input bit s);
    exp_t e;
    int x, y;
    @(negedge clk);
    case ($urandom % 4)
      0: begin x = m_bx - 3 + int'($urandom % 22); y = m_by - 3 + int'($urandom % 22); end
      1: begin x = m_pad - 3 + int'($urandom % 102); y = 437 + int'($urandom % 18); end
      default: begin x = int'($urandom % 800); y = int'($urandom % 525); end
    endcase
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    bus.i_frame_tick = tk; bus.i_btn_left = l; bus.i_btn_right = r; bus.i_btn_start = s;
    bus.i_x = 16'(x); bus.i_y = 16'(y);
    e.ball_on = (x >= m_bx && x < m_bx + 16 && y >= m_by && y < m_by + 16) ? 1 : 0;
    e.pad_on  = (x >= m_pad && x < m_pad + 96 && y >= 440 && y < 452) ? 1 : 0;
    e.px = e.ball_on ? x - m_bx : 0;
    e.py = e.ball_on ? y - m_by : 0;
    e.qx = e.pad_on ? x - m_pad : 0;
    e.qy = e.pad_on ? 11 - (y - 440) : 0;
    if (tk) model_tick(l, r, s);
    else begin m_bounce = 0; m_miss = 0; m_phit = 0; end
    e.bx = m_bx; e.by = m_by; e.pad = m_pad; e.st = m_st; e.lives = m_lives;
    e.score = m_score; e.bounce = m_bounce; e.miss = m_miss;
    q.push_back(e);
  endtask

  // Idle cycles with junk buttons (ignored), then one frame tick.
  task automatic tick(input bit l, input bit r, input bit s);
    int gap;
    gap = int'($urandom_range(1, 3));
    for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1'b1, l, r, s);
  endtask

  // mode 0: steer to catch, 1: steer away, 2: random buttons.
  task automatic play_tick(input int mode);
    bit l, r, s;
    int tgt;
    l = 1'($urandom); r = 1'($urandom); s = ($urandom % 4) == 0;
    if (m_st == S_SERVE && mode != 2) s = ($urandom % 8) == 0;
    if (m_st == S_PLAY && mode == 0) begin
      tgt = m_bx - 40;
      if (tgt < 0) tgt = 0;
      if (tgt > 544) tgt = 544;
      l = m_pad > tgt; r = m_pad < tgt;
    end else if (m_st == S_PLAY && mode == 1) begin
      r = m_bx < 300; l = !r;
    end
    tick(l, r, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.i_frame_tick = 1'b0; bus.i_btn_left = 1'b0; bus.i_btn_right = 1'b0;
    bus.i_btn_start = 1'b0; bus.i_x = '0; bus.i_y = '0;
    #1;
    chk("rst_pad_x", int'(bus.o_pad_x), 272);
    chk("rst_ball_x", int'(bus.o_ball_x), 312);
    chk("rst_ball_y", int'(bus.o_ball_y), 424);
    chk("rst_lives", int'(bus.o_lives), 3);
    chk("rst_score", int'(bus.o_score), 0);
    chk("rst_state", int'(bus.o_state), S_IDLE);
    chk("rst_bounce", int'(bus.o_bounce), 0);
    chk("rst_miss", int'(bus.o_miss), 0);
    chk("rst_ball_on", int'(bus.o_ball_on), 0);
    chk("rst_pad_on", int'(bus.o_pad_on), 0);
    chk("rst_by", int'(bus.o_by), 0);
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a fresh result one edge after stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ball_x", int'(bus.o_ball_x), e.bx);
        chk("ball_y", int'(bus.o_ball_y), e.by);
        chk("pad_x", int'(bus.o_pad_x), e.pad);
        chk("state", int'(bus.o_state), e.st);
        chk("lives", int'(bus.o_lives), e.lives);
        chk("score", int'(bus.o_score), e.score);
        chk("bounce", int'(bus.o_bounce), e.bounce);
        chk("miss", int'(bus.o_miss), e.miss);
        chk("ball_on", int'(bus.o_ball_on), e.ball_on);
        chk("pad_on", int'(bus.o_pad_on), e.pad_on);
        chk("px", int'(bus.o_px), e.px);
        chk("py", int'(bus.o_py), e.py);
        chk("bx", int'(bus.o_bx), e.qx);
        chk("by", int'(bus.o_by), e.qy);
      end
    end
  end

  initial begin
    int n, nsat;
    rst = 1'b1;
    bus.i_frame_tick = 1'b0; bus.i_btn_left = 1'b0; bus.i_btn_right = 1'b0;
    bus.i_btn_start = 1'b0; bus.i_x = '0; bus.i_y = '0;
    model_reset();
    do_reset();

    // Held start: IDLE -> SERVE -> PLAY, then the first move.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    repeat (40) play_tick(2);

    // Mid-frame asynchronous reset.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();

    // Paddle clamp at the right edge while serving, then opposing buttons.
    tick(1'b0, 1'b0, 1'b1);
    repeat (100) tick(1'b0, 1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);

    // Catch until the score has saturated and one more hit was taken.
    n = 0; nsat = 0;
    while (!(m_score == SMAX && nsat >= 2)) begin
      if (n >= 12000) begin
        n_checks++; n_errors++;
        $display("FAIL catch_phase: got %0d ticks without saturating, score %0d required %0d", n, m_score, SMAX);
        break;
      end
      play_tick(0);
      n++;
      if (m_phit == 1 && m_score == SMAX) nsat++;
    end

    // Drop the ball until the game is over.
    n = 0;
    while (m_st != S_OVER) begin
      if (n >= 8000) begin
        n_checks++; n_errors++;
        $display("FAIL drop_phase: got state %0d after %0d ticks required %0d", m_st, n, S_OVER);
        break;
      end
      play_tick(1);
      n++;
    end

    // Restart from OVER, then free play.
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (300) play_tick(2);

    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pong_engine.md
# pong_engine

Frame-rate game engine for the VGA demo: a parametrised successor to the single bouncing box. It owns ball and paddle positions, wall and paddle collisions, miss detection, lives, score and a serve/play/game-over state machine. It also produces the per-pixel sprite hit and sprite-relative coordinates consumed by the sprite ROMs and the colour mux. It sits between the VGA timing generator (`x`, `y`, `frame_tick`) and the RGB output stage.

## Interface
- `CW`, 16: coordinate width.
- `SCREEN_W` / `SCREEN_H`, 640 / 480: drawable area.
- `BALL_W` / `BALL_H`, 16 / 16: ball size.
- `PAD_Y` / `PAD_W` / `PAD_H`, 440 / 96 / 12: paddle top row and size.
- `BALL_DX` / `BALL_DY` / `PAD_SPEED`, 2 / 2 / 4: pixels moved per frame.
- `LIVES`, 3: lives per game.
- `MISS_FRAMES`, 60: pause length after a miss.
- `SCORE_W`, 8: score width; the score saturates.
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `btn_left` / `btn_right` / `btn_start` in 1: active-high, already synchronised and debounced.
- `x`, `y` in CW: current pixel.
- `ball_x`, `ball_y`, `pad_x` out CW: top-left positions.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- `lives` out 3; `score` out SCORE_W.
- `ball_on`, `pad_on` out 1: pixel lies inside the sprite.
- `px`, `py` out CW: pixel offset inside the ball; 0 when outside.
- `bx`, `by` out CW: pixel offset inside the paddle; 0 when outside.
- `bounce`, `miss` out 1: one-cycle event pulses.

## Operation
- **Update rule.** All game state updates only in the cycle where `frame_tick`=1; it holds otherwise. Buttons are sampled in that cycle only.
- **Paddle.**
  - `btn_left` only: move left by PAD_SPEED, clamped at 0.
  - `btn_right` only: move right by PAD_SPEED, clamped at SCREEN_W−PAD_W.
  - Both or neither pressed: hold.
  - The paddle moves in every state except OVER.
- **Ball direction.** Signed direction bits `dir_x` and `dir_y`; 1 means negative.
- **IDLE.** Ball parked. On `btn_start`: go to SERVE.
- **SERVE.** Ball tracks the paddle: `ball_x` = `pad_x` + (PAD_W−BALL_W)/2, `ball_y` = PAD_Y−BALL_H. On `btn_start`: go to PLAY with `dir_y`=1. `dir_x`=1 if `btn_left` is held, otherwise 0.
- **PLAY, each tick.**
  - Compute the next position with unsigned arithmetic in CW+1 bits.
  - X walls: if next x ≤ 0 or ≥ SCREEN_W−BALL_W, clamp to that limit and flip `dir_x`.
  - Top wall: if next y ≤ 0, clamp to 0 and flip `dir_y`.
  - Both axes may flip in the same tick (corner).
- **Paddle hit (PLAY).**
  - Conditions: `dir_y`=0, next `ball_y`+BALL_H ≥ PAD_Y, current `ball_y`+BALL_H ≤ PAD_Y, and horizontal overlap (`ball_x`+BALL_W > `pad_x` and `ball_x` < `pad_x`+PAD_W).
  - Response: set `ball_y`=PAD_Y−BALL_H, set `dir_y`=1, pulse `bounce`, increment `score` (saturating at all-ones).
  - A paddle hit takes priority over a miss in the same tick.
- **Miss (PLAY).**
  - Condition: next `ball_y` ≥ SCREEN_H−BALL_H without a paddle hit.
  - Response: pulse `miss`, decrement `lives`, load the frame counter with MISS_FRAMES, go to MISS.
- **MISS.** Ball frozen. The counter decrements per tick. At 0: go to OVER if `lives`=0, else SERVE.
- **OVER.** Ball and paddle frozen. On `btn_start`: restore `lives`=LIVES, set `score`=0, recentre the paddle, go to SERVE.
- **Wall bounces.** Also pulse `bounce`; no score change.

## Timing
- **Reset values.**
  - `state`=IDLE, `pad_x`=(SCREEN_W−PAD_W)/2, ball at the serve position.
  - `dir_x`=`dir_y`=0, `lives`=LIVES, `score`=0, counter=0.
  - `bounce`=`miss`=0, all pixel outputs 0.
- **Tick latency.** Positions, `state`, `lives` and `score` change on the clock edge that samples `frame_tick`; they are valid on the next cycle. The event pulses are asserted in that same cycle, for exactly one cycle.
- **Pixel path.** `ball_on`, `pad_on`, `px`, `py`, `bx`, `by` are registered one cycle after `x`/`y`. The consumer delays sync by 1.
- `by` = PAD_H−1−(`y`−PAD_Y), which flips the paddle sprite vertically.
- **Mid-frame reset.** Asserting `rst` mid-frame forces the reset values immediately (asynchronous). The first update after release happens at the next `frame_tick`.
- **Held start.** A `btn_start` held across several ticks advances only one state per tick; IDLE→SERVE→PLAY therefore takes 2 ticks.

## Structure
- Shared package `pong_pkg`: state encodings, the `dir` encoding, and the serve/centre constant functions.
- Sub-module `pong_axis` is instantiated twice, once for x and once for y.
  - Parameters: `LO`, `HI`, `STEP`.
  - Inputs: `pos`, `dir`, `en`.
  - Outputs: `nxt_pos`, `nxt_dir`, `hit_lo`, `hit_hi`.
  - Purely combinational; clamps and reflects.
- Top level: FSM, paddle register, collision priority, counters and the pixel pipeline.

## Test plan
- Reset mid-simulation → `pad_x`=272, `ball_x`=312, `ball_y`=424, `lives`=3, `score`=0, `state`=0, pulses low.
- `btn_start` held for 2 ticks → SERVE, then PLAY; the tick after that gives `ball_y`=422, `ball_x`=314.
- `btn_right` held for 100 ticks in SERVE → `pad_x` reaches 544 after 68 ticks and holds; the ball tracks at 584. Both buttons held → no motion.
- Ball in PLAY at `ball_x`=622 moving right → next tick `ball_x`=624 with `bounce` pulse and `dir_x`=1; following tick `ball_x`=622.
- Ball descending onto the paddle centre → `ball_y`=424, `dir_y`=1, `score` 0→1, one `bounce`. Ball descending outside the paddle → `miss`, `lives` 3→2, 60 ticks in MISS, then SERVE.
- Third miss → `lives`=0, MISS, then OVER. Then `btn_start` → SERVE with `lives`=3, `score`=0, `pad_x`=272. A `score` at 255 plus a paddle hit stays at 255.
